// File: rtl/c64_bus_initiator.sv
// -----------------------------------------------------------------------------
// c64_bus_initiator
//
// Bring-up / production-test initiator for the C64 PLA macro. Each accepted
// command replays one CPU/VIC bus cycle on the PLA inputs:
//   SETUP   : address/control driven, CASn high, for SETUP_CYC cycles
//   STROBE  : CASn low; chip selects are captured SAMPLE_CYC cycles in, and in
//             parallel the CASn-fall to CASRAMn-low delay is measured (bounded
//             by TIMEOUT)
//   RELEASE : CASn and OEn high for HOLD_CYC cycles
//   RESP    : the captured result is offered on the rsp_* handshake
// Only one transaction is ever in flight.
//
// Optional feature (compile-time macro C64BUS_STATS_EN):
//   adds stat_txn / stat_tmo transaction and timeout counters (saturating).
//
// Ports:
//   clk_i, rst_override_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_a, cmd_va, cmd_rw_n,
//   cmd_aec_n, cmd_ba, cmd_cfg     values to replay on the PLA inputs
//   bus_a .. bus_cfg               registered drives to the PLA inputs
//   bus_cas_n, bus_oe_n            CASn strobe and PLA output enable
//   pla_cs_n                       asynchronous chip selects from the PLA
//                                  {CASRAMn,BASICn,KERNALn,CHAROMn,GRWn,IOn,
//                                   ROMLn,ROMHn}
//   rsp_valid/rsp_ready            response handshake
//   rsp_cs_n                       captured (synchronized) chip selects
//   rsp_cas_dly                    CASn fall to synchronized CASRAMn low, cycles
//   rsp_timeout                    CASRAMn not seen low within TIMEOUT cycles
//   stat_txn, stat_tmo             (C64BUS_STATS_EN only) statistics counters
// -----------------------------------------------------------------------------
module c64_bus_initiator #(
    parameter int unsigned SETUP_CYC  = 4,
    parameter int unsigned SAMPLE_CYC = 8,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rst_override_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_a,
    input  logic [2:0]  cmd_va,
    input  logic        cmd_rw_n,
    input  logic        cmd_aec_n,
    input  logic        cmd_ba,
    input  logic [4:0]  cmd_cfg,

    output logic [3:0]  bus_a,
    output logic [2:0]  bus_va,
    output logic        bus_rw_n,
    output logic        bus_aec_n,
    output logic        bus_ba,
    output logic [4:0]  bus_cfg,
    output logic        bus_cas_n,
    output logic        bus_oe_n,

    input  logic [7:0]  pla_cs_n,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_cs_n,
    output logic [7:0]  rsp_cas_dly,
    output logic        rsp_timeout
`ifdef C64BUS_STATS_EN
    ,
    output logic [15:0] stat_txn,
    output logic [15:0] stat_tmo
`endif
);

    // Terminal counts for the 8-bit phase counter; all bounds are <= 255 so
    // the counter never wraps.
    localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYC - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);
    localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);
    localparam logic [7:0] TMO_VAL     = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_RELEASE,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cmd_ready_q, cmd_ready_d;

    logic [3:0]  bus_a_q, bus_a_d;
    logic [2:0]  bus_va_q, bus_va_d;
    logic        bus_rw_n_q, bus_rw_n_d;
    logic        bus_aec_n_q, bus_aec_n_d;
    logic        bus_ba_q, bus_ba_d;
    logic [4:0]  bus_cfg_q, bus_cfg_d;
    logic        bus_cas_n_q, bus_cas_n_d;
    logic        bus_oe_n_q, bus_oe_n_d;

    logic [7:0]  sync1_q, sync2_q;

    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_cs_n_q, rsp_cs_n_d;
    logic [7:0]  rsp_cas_dly_q, rsp_cas_dly_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    // Completion flags for the two concurrent STROBE activities.
    logic        search_done_q, search_done_d;
    logic        cap_done_q, cap_done_d;

`ifdef C64BUS_STATS_EN
    logic [15:0] stat_txn_q, stat_txn_d;
    logic [15:0] stat_tmo_q, stat_tmo_d;
`endif

    logic        cmd_fire;
    logic        rsp_fire;
    logic        in_strobe;
    logic        casram_sync_n;
    logic        dly_hit;
    logic        dly_tmo;
    logic        cap_now;
    logic        strobe_done;

    assign cmd_fire      = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
    assign rsp_fire      = rsp_valid_q && rsp_ready;
    assign in_strobe     = (state_q == S_STROBE);
    assign casram_sync_n = sync2_q[7];

    // The delay search resolves once: either the first synchronized
    // CASRAMn low, or the timeout on the last permitted cycle. A low seen on
    // the timeout cycle itself still counts as a hit.
    assign dly_hit = in_strobe && !search_done_q && !casram_sync_n;
    assign dly_tmo = in_strobe && !search_done_q && casram_sync_n
                     && (cnt_q == TMO_LAST);
    assign cap_now = in_strobe && !cap_done_q && (cnt_q == SAMPLE_LAST);

    // STROBE ends only when both the capture and the delay search are done,
    // counting anything that completes in the current cycle.
    assign strobe_done = (search_done_q || dly_hit || dly_tmo)
                         && (cap_done_q || cap_now);

    // State and datapath registers. Reset returns every drive to its idle
    // value immediately, so an aborted transaction releases CASn/OEn at once.
    always_ff @(posedge clk_i or negedge rst_override_n) begin
        if (!rst_override_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            cmd_ready_q   <= 1'b0;
            bus_a_q       <= 4'h0;
            bus_va_q      <= 3'b111;
            bus_rw_n_q    <= 1'b1;
            bus_aec_n_q   <= 1'b1;
            bus_ba_q      <= 1'b1;
            bus_cfg_q     <= 5'b11111;
            bus_cas_n_q   <= 1'b1;
            bus_oe_n_q    <= 1'b1;
            sync1_q       <= 8'hFF;
            sync2_q       <= 8'hFF;
            rsp_valid_q   <= 1'b0;
            rsp_cs_n_q    <= 8'hFF;
            rsp_cas_dly_q <= 8'd0;
            rsp_timeout_q <= 1'b0;
            search_done_q <= 1'b0;
            cap_done_q    <= 1'b0;
`ifdef C64BUS_STATS_EN
            stat_txn_q    <= 16'd0;
            stat_tmo_q    <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            bus_a_q       <= bus_a_d;
            bus_va_q      <= bus_va_d;
            bus_rw_n_q    <= bus_rw_n_d;
            bus_aec_n_q   <= bus_aec_n_d;
            bus_ba_q      <= bus_ba_d;
            bus_cfg_q     <= bus_cfg_d;
            bus_cas_n_q   <= bus_cas_n_d;
            bus_oe_n_q    <= bus_oe_n_d;
            sync1_q       <= pla_cs_n;
            sync2_q       <= sync1_q;
            rsp_valid_q   <= rsp_valid_d;
            rsp_cs_n_q    <= rsp_cs_n_d;
            rsp_cas_dly_q <= rsp_cas_dly_d;
            rsp_timeout_q <= rsp_timeout_d;
            search_done_q <= search_done_d;
            cap_done_q    <= cap_done_d;
`ifdef C64BUS_STATS_EN
            stat_txn_q    <= stat_txn_d;
            stat_tmo_q    <= stat_tmo_d;
`endif
        end
    end

    // Next-state logic: phase sequencing driven by the shared counter and the
    // STROBE completion condition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                if (strobe_done) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath logic. Handshake and strobe outputs are registered
    // decodes of the next state, so cmd_ready drops on the accepting edge and
    // CASn is low exactly while in STROBE.
    always_comb begin
        cnt_d         = cnt_q;
        bus_a_d       = bus_a_q;
        bus_va_d      = bus_va_q;
        bus_rw_n_d    = bus_rw_n_q;
        bus_aec_n_d   = bus_aec_n_q;
        bus_ba_d      = bus_ba_q;
        bus_cfg_d     = bus_cfg_q;
        rsp_cs_n_d    = rsp_cs_n_q;
        rsp_cas_dly_d = rsp_cas_dly_q;
        rsp_timeout_d = rsp_timeout_q;
        search_done_d = search_done_q;
        cap_done_d    = cap_done_q;

        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        bus_cas_n_d = (state_d != S_STROBE);
        bus_oe_n_d  = !((state_d == S_SETUP) || (state_d == S_STROBE));

        unique case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    bus_a_d       = cmd_a;
                    bus_va_d      = cmd_va;
                    bus_rw_n_d    = cmd_rw_n;
                    bus_aec_n_d   = cmd_aec_n;
                    bus_ba_d      = cmd_ba;
                    bus_cfg_d     = cmd_cfg;
                    cnt_d         = 8'd0;
                    rsp_timeout_d = 1'b0;
                    search_done_d = 1'b0;
                    cap_done_d    = 1'b0;
                end
            end
            S_SETUP: begin
                cnt_d = (cnt_q == SETUP_LAST) ? 8'd0 : cnt_q + 8'd1;
            end
            S_STROBE: begin
                cnt_d = strobe_done ? 8'd0 : cnt_q + 8'd1;
                // cnt counts cycles since CASn fell, so the first low seen
                // in cycle cnt is reported as cnt+1 (sync latency included).
                if (dly_hit) begin
                    rsp_cas_dly_d = cnt_q + 8'd1;
                    search_done_d = 1'b1;
                end else if (dly_tmo) begin
                    rsp_cas_dly_d = TMO_VAL;
                    rsp_timeout_d = 1'b1;
                    search_done_d = 1'b1;
                end
                if (cap_now) begin
                    rsp_cs_n_d = sync2_q;
                    cap_done_d = 1'b1;
                end
            end
            S_RELEASE: begin
                cnt_d = (cnt_q == HOLD_LAST) ? 8'd0 : cnt_q + 8'd1;
            end
            S_RESP: begin
                cnt_d = 8'd0;
            end
            default: begin
                cnt_d = 8'd0;
            end
        endcase
    end

`ifdef C64BUS_STATS_EN
    // Statistics: both counters advance on the response handshake and stick
    // at all-ones rather than wrapping.
    always_comb begin
        stat_txn_d = stat_txn_q;
        stat_tmo_d = stat_tmo_q;
        if (rsp_fire) begin
            if (stat_txn_q != 16'hFFFF) begin
                stat_txn_d = stat_txn_q + 16'd1;
            end
            if (rsp_timeout_q && (stat_tmo_q != 16'hFFFF)) begin
                stat_tmo_d = stat_tmo_q + 16'd1;
            end
        end
    end

    assign stat_txn = stat_txn_q;
    assign stat_tmo = stat_tmo_q;
`endif

    assign cmd_ready   = cmd_ready_q;
    assign bus_a       = bus_a_q;
    assign bus_va      = bus_va_q;
    assign bus_rw_n    = bus_rw_n_q;
    assign bus_aec_n   = bus_aec_n_q;
    assign bus_ba      = bus_ba_q;
    assign bus_cfg     = bus_cfg_q;
    assign bus_cas_n   = bus_cas_n_q;
    assign bus_oe_n    = bus_oe_n_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_cs_n    = rsp_cs_n_q;
    assign rsp_cas_dly = rsp_cas_dly_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_c64_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_c64_bus_initiator
//
// Scoreboard bench for c64_bus_initiator. Two instances share the clock,
// reset and command fields: instance A uses default parameters, instance B
// uses TIMEOUT=20. Each instance has a small PLA model that drives fixed
// chip-select bits while OEn is low and pulls CASRAMn low a programmed number
// of clocks after CASn falls (0 = never). Expected responses are queued when
// a command is issued; per-instance monitors pop and compare them whenever
// rsp_valid rises, and check that held responses stay stable.
// Honours C64BUS_STATS_EN for the statistics outputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_c64_bus_initiator;

    typedef struct {
        string      name;
        logic [7:0] cs;
        logic [7:0] dly;
        logic       tmo;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_override_n;

    logic [3:0]  cmd_a;
    logic [2:0]  cmd_va;
    logic        cmd_rw_n;
    logic        cmd_aec_n;
    logic        cmd_ba;
    logic [4:0]  cmd_cfg;

    logic        da_cmd_valid, da_cmd_ready, db_cmd_valid, db_cmd_ready;
    logic [3:0]  da_bus_a, db_bus_a;
    logic [2:0]  da_bus_va, db_bus_va;
    logic        da_bus_rw_n, db_bus_rw_n, da_bus_aec_n, db_bus_aec_n;
    logic        da_bus_ba, db_bus_ba;
    logic [4:0]  da_bus_cfg, db_bus_cfg;
    logic        da_bus_cas_n, db_bus_cas_n, da_bus_oe_n, db_bus_oe_n;
    logic [7:0]  da_pla_cs_n, db_pla_cs_n;
    logic        da_rsp_valid, db_rsp_valid, da_rsp_ready, db_rsp_ready;
    logic [7:0]  da_rsp_cs_n, db_rsp_cs_n, da_rsp_cas_dly, db_rsp_cas_dly;
    logic        da_rsp_timeout, db_rsp_timeout;
`ifdef C64BUS_STATS_EN
    logic [15:0] da_stat_txn, da_stat_tmo, db_stat_txn, db_stat_tmo;
`endif

    int          assert_count = 0;
    int          fail_count   = 0;
    exp_t        exp_q_a[$];
    exp_t        exp_q_b[$];
    exp_t        cur_a, cur_b;
    bit          held_a, held_b;
    int          exp_txn_a = 0, exp_tmo_a = 0, exp_txn_b = 0, exp_tmo_b = 0;

    logic [6:0]  model_other_a = 7'h7F, model_other_b = 7'h7F;
    int          model_delay_a = 0, model_delay_b = 0;
    int          cas_cnt_a = 0, cas_cnt_b = 0, last_run_b = 0;

    always #5 clk_i = ~clk_i;

    c64_bus_initiator u_dut_a (
        .clk_i         (clk_i),
        .rst_override_n(rst_override_n),
        .cmd_valid     (da_cmd_valid),
        .cmd_ready     (da_cmd_ready),
        .cmd_a         (cmd_a),
        .cmd_va        (cmd_va),
        .cmd_rw_n      (cmd_rw_n),
        .cmd_aec_n     (cmd_aec_n),
        .cmd_ba        (cmd_ba),
        .cmd_cfg       (cmd_cfg),
        .bus_a         (da_bus_a),
        .bus_va        (da_bus_va),
        .bus_rw_n      (da_bus_rw_n),
        .bus_aec_n     (da_bus_aec_n),
        .bus_ba        (da_bus_ba),
        .bus_cfg       (da_bus_cfg),
        .bus_cas_n     (da_bus_cas_n),
        .bus_oe_n      (da_bus_oe_n),
        .pla_cs_n      (da_pla_cs_n),
        .rsp_valid     (da_rsp_valid),
        .rsp_ready     (da_rsp_ready),
        .rsp_cs_n      (da_rsp_cs_n),
        .rsp_cas_dly   (da_rsp_cas_dly),
        .rsp_timeout   (da_rsp_timeout)
`ifdef C64BUS_STATS_EN
        ,
        .stat_txn      (da_stat_txn),
        .stat_tmo      (da_stat_tmo)
`endif
    );

    c64_bus_initiator #(.TIMEOUT(20)) u_dut_b (
        .clk_i         (clk_i),
        .rst_override_n(rst_override_n),
        .cmd_valid     (db_cmd_valid),
        .cmd_ready     (db_cmd_ready),
        .cmd_a         (cmd_a),
        .cmd_va        (cmd_va),
        .cmd_rw_n      (cmd_rw_n),
        .cmd_aec_n     (cmd_aec_n),
        .cmd_ba        (cmd_ba),
        .cmd_cfg       (cmd_cfg),
        .bus_a         (db_bus_a),
        .bus_va        (db_bus_va),
        .bus_rw_n      (db_bus_rw_n),
        .bus_aec_n     (db_bus_aec_n),
        .bus_ba        (db_bus_ba),
        .bus_cfg       (db_bus_cfg),
        .bus_cas_n     (db_bus_cas_n),
        .bus_oe_n      (db_bus_oe_n),
        .pla_cs_n      (db_pla_cs_n),
        .rsp_valid     (db_rsp_valid),
        .rsp_ready     (db_rsp_ready),
        .rsp_cs_n      (db_rsp_cs_n),
        .rsp_cas_dly   (db_rsp_cas_dly),
        .rsp_timeout   (db_rsp_timeout)
`ifdef C64BUS_STATS_EN
        ,
        .stat_txn      (db_stat_txn),
        .stat_tmo      (db_stat_tmo)
`endif
    );

    // PLA models: cas_cnt counts rising edges since CASn fell, so a delay of
    // N makes CASRAMn low when sampled on the Nth edge after the fall.
    always @(negedge clk_i) begin
        if (da_bus_cas_n) cas_cnt_a = 0;
        else              cas_cnt_a = cas_cnt_a + 1;
        da_pla_cs_n = da_bus_oe_n ? 8'hFF :
            {((model_delay_a != 0) && (cas_cnt_a >= model_delay_a)) ? 1'b0 : 1'b1,
             model_other_a};
    end

    always @(negedge clk_i) begin
        if (db_bus_cas_n) begin
            if (cas_cnt_b != 0) last_run_b = cas_cnt_b;
            cas_cnt_b = 0;
        end else begin
            cas_cnt_b = cas_cnt_b + 1;
        end
        db_pla_cs_n = db_bus_oe_n ? 8'hFF :
            {((model_delay_b != 0) && (cas_cnt_b >= model_delay_b)) ? 1'b0 : 1'b1,
             model_other_b};
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor A: pops on a new response, then checks it stays put while held.
    always @(negedge clk_i) begin
        if (!rst_override_n) begin
            held_a = 0;
        end else if (da_rsp_valid) begin
            if (!held_a) begin
                if (exp_q_a.size() == 0) begin
                    checkOutput("A unexpected rsp_valid", da_rsp_valid, 0);
                end else begin
                    cur_a = exp_q_a.pop_front();
                    checkOutput({cur_a.name, " rsp_cs_n"}, da_rsp_cs_n, cur_a.cs);
                    checkOutput({cur_a.name, " rsp_cas_dly"}, da_rsp_cas_dly, cur_a.dly);
                    checkOutput({cur_a.name, " rsp_timeout"}, da_rsp_timeout, cur_a.tmo);
                end
            end else begin
                checkOutput({cur_a.name, " held rsp_cs_n"}, da_rsp_cs_n, cur_a.cs);
                checkOutput({cur_a.name, " held rsp_cas_dly"}, da_rsp_cas_dly, cur_a.dly);
                checkOutput({cur_a.name, " held rsp_timeout"}, da_rsp_timeout, cur_a.tmo);
            end
            checkOutput("A cmd_ready during resp", da_cmd_ready, 0);
            held_a = !da_rsp_ready;
        end else begin
            held_a = 0;
        end
    end

    // Monitor B: same scheme for the short-timeout instance.
    always @(negedge clk_i) begin
        if (!rst_override_n) begin
            held_b = 0;
        end else if (db_rsp_valid) begin
            if (!held_b) begin
                if (exp_q_b.size() == 0) begin
                    checkOutput("B unexpected rsp_valid", db_rsp_valid, 0);
                end else begin
                    cur_b = exp_q_b.pop_front();
                    checkOutput({cur_b.name, " rsp_cs_n"}, db_rsp_cs_n, cur_b.cs);
                    checkOutput({cur_b.name, " rsp_cas_dly"}, db_rsp_cas_dly, cur_b.dly);
                    checkOutput({cur_b.name, " rsp_timeout"}, db_rsp_timeout, cur_b.tmo);
                end
            end
            held_b = !db_rsp_ready;
        end else begin
            held_b = 0;
        end
    end

    // Issue one command on instance 0 (A) or 1 (B), optionally queueing the
    // expected response, and check the PLA drives latched on acceptance.
    task automatic applyStimulus(input int which, input string name,
                                 input logic [3:0] a, input logic rw_n,
                                 input logic [6:0] other, input int delay,
                                 input logic [7:0] exp_cs, input logic [7:0] exp_dly,
                                 input logic exp_tmo, input bit push);
        exp_t e;
        bit   accepted = 0;
        e.name = name;
        e.cs   = exp_cs;
        e.dly  = exp_dly;
        e.tmo  = exp_tmo;
        if (which == 0) begin
            model_other_a = other;
            model_delay_a = delay;
            if (push) begin
                exp_q_a.push_back(e);
                exp_txn_a++;
                if (exp_tmo) exp_tmo_a++;
            end
        end else begin
            model_other_b = other;
            model_delay_b = delay;
            if (push) begin
                exp_q_b.push_back(e);
                exp_txn_b++;
                if (exp_tmo) exp_tmo_b++;
            end
        end
        @(posedge clk_i); #1;
        cmd_a    = a;
        cmd_rw_n = rw_n;
        if (which == 0) da_cmd_valid = 1'b1;
        else            db_cmd_valid = 1'b1;
        for (int i = 0; i < 64 && !accepted; i++) begin
            @(negedge clk_i);
            if ((which == 0) ? da_cmd_ready : db_cmd_ready) accepted = 1;
        end
        @(posedge clk_i); #1;
        da_cmd_valid = 1'b0;
        db_cmd_valid = 1'b0;
        checkOutput({name, " accepted"}, accepted, 1);
        @(negedge clk_i);
        if (which == 0) begin
            checkOutput({name, " bus_a"}, da_bus_a, a);
            checkOutput({name, " bus_rw_n"}, da_bus_rw_n, rw_n);
            checkOutput({name, " bus_cfg"}, da_bus_cfg, cmd_cfg);
            checkOutput({name, " bus_oe_n"}, da_bus_oe_n, 0);
            checkOutput({name, " cmd_ready after accept"}, da_cmd_ready, 0);
        end else begin
            checkOutput({name, " bus_a"}, db_bus_a, a);
            checkOutput({name, " bus_oe_n"}, db_bus_oe_n, 0);
            checkOutput({name, " cmd_ready after accept"}, db_cmd_ready, 0);
        end
    endtask

    // Wait (bounded) for the monitor to consume every queued expectation,
    // then step past the response handshake edge.
    task automatic waitDrain(input int which, input string name);
        for (int i = 0; i < 1000; i++) begin
            if (((which == 0) ? exp_q_a.size() : exp_q_b.size()) == 0) break;
            @(negedge clk_i);
        end
        checkOutput({name, " drained"}, (which == 0) ? exp_q_a.size() : exp_q_b.size(), 0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        rst_override_n = 1'b0;
        cmd_a = 4'h0; cmd_va = 3'b011; cmd_rw_n = 1'b1;
        cmd_aec_n = 1'b1; cmd_ba = 1'b1; cmd_cfg = 5'b11111;
        da_cmd_valid = 1'b0; db_cmd_valid = 1'b0;
        da_rsp_ready = 1'b1; db_rsp_ready = 1'b1;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset cmd_ready", da_cmd_ready, 0);
        checkOutput("reset rsp_valid", da_rsp_valid, 0);
        checkOutput("reset rsp_cs_n", da_rsp_cs_n, 8'hFF);
        checkOutput("reset rsp_cas_dly", da_rsp_cas_dly, 0);
        checkOutput("reset rsp_timeout", da_rsp_timeout, 0);
        checkOutput("reset bus_a", da_bus_a, 0);
        checkOutput("reset bus_va", da_bus_va, 3'b111);
        checkOutput("reset bus_rw_n", da_bus_rw_n, 1);
        checkOutput("reset bus_aec_n", da_bus_aec_n, 1);
        checkOutput("reset bus_ba", da_bus_ba, 1);
        checkOutput("reset bus_cfg", da_bus_cfg, 5'b11111);
        checkOutput("reset bus_cas_n", da_bus_cas_n, 1);
        checkOutput("reset bus_oe_n", da_bus_oe_n, 1);
        checkOutput("reset B cmd_ready", db_cmd_ready, 0);
        @(posedge clk_i); #1;
        rst_override_n = 1'b1;
        @(negedge clk_i);
        checkOutput("cmd_ready before first edge", da_cmd_ready, 0);
        @(negedge clk_i);
        checkOutput("cmd_ready one cycle after reset", da_cmd_ready, 1);

        // name, A, rw_n, other chip selects, CASRAMn delay, expected cs/dly/tmo
        applyStimulus(0, "basic_read", 4'hA, 1'b1, 7'h3F, 0, 8'hBF, 8'd255, 1'b1, 1);
        waitDrain(0, "basic_read");
        applyStimulus(0, "ram_dly5", 4'h0, 1'b1, 7'h7F, 5, 8'h7F, 8'd7, 1'b0, 1);
        waitDrain(0, "ram_dly5");
        applyStimulus(0, "ram_dly1", 4'h8, 1'b1, 7'h7D, 1, 8'h7D, 8'd3, 1'b0, 1);
        waitDrain(0, "ram_dly1");
        applyStimulus(0, "ram_dly6", 4'h1, 1'b1, 7'h7F, 6, 8'h7F, 8'd8, 1'b0, 1);
        waitDrain(0, "ram_dly6");
        applyStimulus(0, "write_dly7", 4'h2, 1'b0, 7'h77, 7, 8'hF7, 8'd9, 1'b0, 1);
        waitDrain(0, "write_dly7");
        applyStimulus(0, "io_dly10", 4'hD, 1'b1, 7'h7B, 10, 8'hFB, 8'd12, 1'b0, 1);
        waitDrain(0, "io_dly10");

        // Backpressure: response held for 10 cycles with a new command waiting.
        da_rsp_ready = 1'b0;
        applyStimulus(0, "bp_kernal", 4'hE, 1'b1, 7'h5F, 0, 8'hDF, 8'd255, 1'b1, 1);
        seen = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk_i);
            if (da_rsp_valid) seen = 1;
        end
        checkOutput("bp rsp_valid reached", seen, 1);
        @(posedge clk_i); #1;
        model_other_a = 7'h7F;
        model_delay_a = 2;
        cmd_a = 4'h3;
        cmd_rw_n = 1'b1;
        cur_b.name = "bp_next";
        cur_b.cs   = 8'h7F;
        cur_b.dly  = 8'd4;
        cur_b.tmo  = 1'b0;
        exp_q_a.push_back(cur_b);
        exp_txn_a++;
        da_cmd_valid = 1'b1;
        repeat (10) @(posedge clk_i);
        #1 da_rsp_ready = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("bp cmd_ready after rsp handshake", da_cmd_ready, 1);
        checkOutput("bp rsp_valid dropped", da_rsp_valid, 0);
        checkOutput("bp not accepted during resp", da_bus_oe_n, 1);
        @(posedge clk_i); #1;
        da_cmd_valid = 1'b0;
        @(negedge clk_i);
        checkOutput("bp_next accepted", da_bus_oe_n, 0);
        checkOutput("bp_next bus_a", da_bus_a, 4'h3);
        waitDrain(0, "bp_next");

        // Reset during STROBE: drives release at once and no response follows.
        applyStimulus(0, "reset_mid", 4'h5, 1'b1, 7'h7F, 3, 8'h00, 8'd0, 1'b0, 0);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk_i);
            if (!da_bus_cas_n) seen = 1;
        end
        checkOutput("reset_mid reached strobe", seen, 1);
        repeat (2) @(posedge clk_i);
        #3 rst_override_n = 1'b0;
        #1;
        checkOutput("async reset bus_cas_n", da_bus_cas_n, 1);
        checkOutput("async reset bus_oe_n", da_bus_oe_n, 1);
        checkOutput("async reset rsp_valid", da_rsp_valid, 0);
        checkOutput("async reset cmd_ready", da_cmd_ready, 0);
        checkOutput("async reset bus_a", da_bus_a, 0);
        @(posedge clk_i); #1;
        rst_override_n = 1'b1;
        @(negedge clk_i);
        checkOutput("post-reset cmd_ready low", da_cmd_ready, 0);
        @(negedge clk_i);
        checkOutput("post-reset cmd_ready high", da_cmd_ready, 1);
        repeat (20) @(posedge clk_i);
        applyStimulus(0, "after_reset", 4'h7, 1'b1, 7'h7F, 4, 8'h7F, 8'd6, 1'b0, 1);
        waitDrain(0, "after_reset");

        // Short-timeout instance: CASRAMn never asserts.
        applyStimulus(1, "b_timeout20", 4'h0, 1'b1, 7'h7F, 0, 8'hFF, 8'd20, 1'b1, 1);
        waitDrain(1, "b_timeout20");
        checkOutput("b strobe cycles", last_run_b, 20);

        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("A queue empty at end", exp_q_a.size(), 0);
        checkOutput("B queue empty at end", exp_q_b.size(), 0);
        $display("[TB] expected stats A txn=%0d tmo=%0d B txn=%0d tmo=%0d",
                 exp_txn_a, exp_tmo_a, exp_txn_b, exp_tmo_b);
`ifdef C64BUS_STATS_EN
        checkOutput("A stat_txn", da_stat_txn, exp_txn_a);
        checkOutput("A stat_tmo", da_stat_tmo, exp_tmo_a);
        checkOutput("B stat_txn", db_stat_txn, exp_txn_b);
        checkOutput("B stat_tmo", db_stat_tmo, exp_tmo_b);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
